// File: rtl/axi4_mem_responder_if.sv
// AXI4 memory-mapped bus bundle between a DMA master and the memory
// responder; modports give each side its direction.
interface axi4_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a word memory; serves one INCR burst at a time
// on either the read or the write channel.
module axi4_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    axi4_mem_responder_if.slave  s
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int NB    = DATA_WIDTH / 8;

    localparam logic [AW1-1:0] LIMIT = AW1'(4 * MEM_DEPTH);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  bad_q, bad_d;
    logic                  slv_q, slv_d;
    logic                  dec_q, dec_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // One extra bit so a burst running past the top cannot wrap to 0
    function automatic logic [AW1-1:0] beat_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [8:0]            beat
    );
        return {1'b0, base} + (AW1'(beat) << 2);
    endfunction

    logic [AW1-1:0]        wr_addr;
    logic                  wr_oor;
    logic                  wr_last;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic                  aw_bad;
    logic                  ar_bad;
    logic [AW1-1:0]        rd_addr;
    logic                  rd_bad;
    logic                  rd_oor;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;
    logic                  slv_n;
    logic                  dec_n;

    assign aw_bad = (s.awburst != 2'b01) || (s.awsize != 3'b010);
    assign ar_bad = (s.arburst != 2'b01) || (s.arsize != 3'b010);

    assign wr_addr = beat_addr(addr_q, {1'b0, beat_q});
    assign wr_oor  = wr_addr >= LIMIT;
    assign wr_last = beat_q == len_q;
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign wr_en   = (state_q == WR_DATA) && s.wvalid
                     && !bad_q && !wr_oor;

    // Prefetch: beat 0 from the AR bus, otherwise the beat after the current
    assign rd_addr = (state_q == IDLE)
                     ? {1'b0, s.araddr}
                     : beat_addr(addr_q, {1'b0, beat_q} + 9'd1);
    assign rd_bad  = (state_q == IDLE) ? ar_bad : bad_q;
    assign rd_oor  = rd_addr >= LIMIT;
    assign rd_data = (rd_bad || rd_oor)
                     ? '0 : mem[rd_addr[IDX_W+1:2]];
    assign rd_resp = rd_bad ? SLVERR : (rd_oor ? DECERR : OKAY);

    assign slv_n = slv_q || bad_q || (s.wlast != wr_last);
    assign dec_n = dec_q || wr_oor;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        bad_d    = bad_q;
        slv_d    = slv_q;
        dec_d    = dec_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (s.awvalid) begin
                    id_d    = s.awid;
                    addr_d  = s.awaddr;
                    len_d   = s.awlen;
                    beat_d  = '0;
                    bad_d   = aw_bad;
                    slv_d   = 1'b0;
                    dec_d   = 1'b0;
                    state_d = WR_DATA;
                end else if (s.arvalid) begin
                    id_d     = s.arid;
                    addr_d   = s.araddr;
                    len_d    = s.arlen;
                    beat_d   = '0;
                    bad_d    = ar_bad;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_data;
                    rresp_d  = rd_resp;
                    rlast_d  = s.arlen == 8'd0;
                    state_d  = RD_DATA;
                end
            end
            WR_DATA: begin
                if (s.wvalid) begin
                    slv_d = slv_n;
                    dec_d = dec_n;
                    if (wr_last) begin
                        bresp_d = slv_n ? SLVERR
                                : (dec_n ? DECERR : OKAY);
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                if (s.bready) state_d = IDLE;
            end
            RD_DATA: begin
                if (s.rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        rdata_d = rd_data;
                        rresp_d = rd_resp;
                        rlast_d = (beat_q + 8'd1) == len_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            bad_q    <= 1'b0;
            slv_q    <= 1'b0;
            dec_q    <= 1'b0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            bad_q    <= bad_d;
            slv_q    <= slv_d;
            dec_q    <= dec_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Contents survive reset, so the array has no reset branch
    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (s.wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= s.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s.awready = axi_resetn && (state_q == IDLE);
    assign s.arready = axi_resetn && (state_q == IDLE) && !s.awvalid;
    assign s.wready  = state_q == WR_DATA;
    assign s.bvalid  = state_q == WR_RESP;
    assign s.bid     = id_q;
    assign s.bresp   = bresp_q;
    assign s.rid     = id_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign s.rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, arbitration,
// boundary DECERR, unsupported burst SLVERR and reset mid-burst.
module tb_axi4_mem_responder;
    localparam int MEM_DEPTH = 1024;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];
    logic [1:0]  rrbuf [16];

    axi4_mem_responder_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4)
    ) bus ();

    axi4_mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .axi_aclk  (clk),
        .axi_resetn(rst_n),
        .s         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input int last_at,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = 3'd2;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_aw_timeout"}, 0, 1);
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wbuf[i];
            bus.wstrb  = strb;
            bus.wlast  = (i == last_at);
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk({tag, "_w_timeout"}, 0, 1);
            @(posedge clk);
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk({tag, "_b_lat"}, 32'(bus.bvalid), 1);
        bus.bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        chk({tag, "_bid"}, 32'(bus.bid), 32'(id));
        @(posedge clk);
        #1 bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input string tag);
        int n;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = 3'd2;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_ar_timeout"}, 0, 1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        chk({tag, "_r_lat"}, 32'(bus.rvalid), 1);
        bus.rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            chk($sformatf("%s_rvalid%0d", tag, i), 32'(bus.rvalid), 1);
            chk($sformatf("%s_rdata%0d", tag, i), bus.rdata, rbuf[i]);
            chk($sformatf("%s_rresp%0d", tag, i),
                32'(bus.rresp), 32'(rrbuf[i]));
            chk($sformatf("%s_rlast%0d", tag, i),
                32'(bus.rlast), 32'(i == int'(len)));
            chk($sformatf("%s_rid%0d", tag, i), 32'(bus.rid), 32'(id));
            @(posedge clk);
            #1;
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.awid    = '0;
        bus.awaddr  = '0;
        bus.awlen   = '0;
        bus.awsize  = 3'd2;
        bus.awburst = 2'b01;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wlast   = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = 3'd2;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_wready", 32'(bus.wready), 0);
        chk("rst_bvalid", 32'(bus.bvalid), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_rlast", 32'(bus.rlast), 0);
        chk("rst_bresp", 32'(bus.bresp), 0);
        chk("rst_rresp", 32'(bus.rresp), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_bid", 32'(bus.bid), 0);
        chk("rst_rid", 32'(bus.rid), 0);
        rst_n = 1'b1;
        #1 chk("post_rst_awready", 32'(bus.awready), 1);
        @(posedge clk);
        #1;

        wbuf[0] = 32'h1111_1111;
        wbuf[1] = 32'h2222_2222;
        wbuf[2] = 32'h3333_3333;
        wbuf[3] = 32'h4444_4444;
        do_write(4'h5, 32'h100, 8'd3, 2'b01, 4'hF, 3, 2'b00, "wr_incr");

        for (int i = 0; i < 4; i++) begin
            rbuf[i]  = wbuf[i];
            rrbuf[i] = 2'b00;
        end
        do_read(4'h6, 32'h100, 8'd3, "rd_incr");

        wbuf[0] = 32'h1111_1111;
        do_write(4'h1, 32'h200, 8'd0, 2'b01, 4'hF, 0, 2'b00, "wr_full");
        wbuf[0] = 32'hAABB_CCDD;
        do_write(4'h2, 32'h200, 8'd0, 2'b01, 4'b0101, 0, 2'b00, "wr_strb");
        rbuf[0]  = 32'h11BB_11DD;
        rrbuf[0] = 2'b00;
        do_read(4'h2, 32'h200, 8'd0, "rd_strb");

        // Simultaneous AW and AR: write must win
        bus.awid    = 4'h3;
        bus.awaddr  = 32'h300;
        bus.awlen   = 8'd0;
        bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        bus.arid    = 4'h4;
        bus.araddr  = 32'h300;
        bus.arlen   = 8'd0;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        @(negedge clk);
        chk("col_awready", 32'(bus.awready), 1);
        chk("col_arready", 32'(bus.arready), 0);
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        bus.wdata  = 32'h5A5A_5A5A;
        bus.wstrb  = 4'hF;
        bus.wlast  = 1'b1;
        bus.wvalid = 1'b1;
        @(negedge clk);
        chk("col_wready", 32'(bus.wready), 1);
        chk("col_arready_wr", 32'(bus.arready), 0);
        @(posedge clk);
        #1 bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.bready = 1'b1;
        @(negedge clk);
        chk("col_bvalid", 32'(bus.bvalid), 1);
        chk("col_bid", 32'(bus.bid), 3);
        chk("col_arready_b", 32'(bus.arready), 0);
        @(posedge clk);
        #1 bus.bready = 1'b0;
        @(negedge clk);
        chk("col_arready_idle", 32'(bus.arready), 1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk);
        chk("col_rvalid", 32'(bus.rvalid), 1);
        chk("col_rdata", bus.rdata, 32'h5A5A_5A5A);
        chk("col_rid", 32'(bus.rid), 4);
        chk("col_rlast", 32'(bus.rlast), 1);
        @(posedge clk);
        #1 bus.rready = 1'b0;

        // Top of memory: last two words valid, next two past the end
        wbuf[0] = 32'hA0A0_A0A0;
        wbuf[1] = 32'hA1A1_A1A1;
        do_write(4'h7, 32'(4 * MEM_DEPTH - 8), 8'd1, 2'b01, 4'hF, 1,
                 2'b00, "wr_top");
        rbuf[0]  = 32'hA0A0_A0A0;
        rbuf[1]  = 32'hA1A1_A1A1;
        rbuf[2]  = 32'h0;
        rbuf[3]  = 32'h0;
        rrbuf[0] = 2'b00;
        rrbuf[1] = 2'b00;
        rrbuf[2] = 2'b11;
        rrbuf[3] = 2'b11;
        do_read(4'h8, 32'(4 * MEM_DEPTH - 8), 8'd3, "rd_decerr");
        do_write(4'h9, 32'(4 * MEM_DEPTH - 8), 8'd3, 2'b01, 4'hF, 3,
                 2'b11, "wr_decerr");

        wbuf[0] = 32'hDEAD_BEEF;
        wbuf[1] = 32'hCAFE_F00D;
        do_write(4'hA, 32'h100, 8'd1, 2'b10, 4'hF, 1, 2'b10, "wr_wrap");
        rbuf[0]  = 32'h1111_1111;
        rbuf[1]  = 32'h2222_2222;
        rrbuf[0] = 2'b00;
        rrbuf[1] = 2'b00;
        do_read(4'hB, 32'h100, 8'd1, "rd_after_slv");

        wbuf[0] = 32'h0102_0304;
        wbuf[1] = 32'h0506_0708;
        do_write(4'hC, 32'h400, 8'd1, 2'b01, 4'hF, 0, 2'b10, "wr_early_last");

        // Stalled read, then reset in the middle of it
        bus.arid    = 4'hD;
        bus.araddr  = 32'h100;
        bus.arlen   = 8'd3;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        @(negedge clk);
        chk("stall_arready", 32'(bus.arready), 1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_rvalid", 32'(bus.rvalid), 1);
            chk("stall_rdata", bus.rdata, 32'h1111_1111);
            chk("stall_rlast", 32'(bus.rlast), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(bus.rvalid), 0);
        chk("midrst_arready", 32'(bus.arready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rbuf[0]  = 32'h1111_1111;
        rrbuf[0] = 2'b00;
        do_read(4'hE, 32'h100, 8'd0, "rd_post_rst");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
